// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag bundle.
package alu_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    function automatic logic is_shift(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU step: a full logic/arith op, or one single-bit shift step.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             shift_en_i,
    output logic [WIDTH-1:0] res_o,
    output flags_t           flags_o
);

    logic [WIDTH:0] wide;

    always_comb begin
        res_o         = '0;
        wide          = '0;
        flags_o       = '0;
        case (op_i)
            OP_NOT: res_o = ~a_i;
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_ADD: begin
                wide          = {1'b0, a_i} + {1'b0, b_i};
                res_o         = wide[WIDTH-1:0];
                flags_o.carry = wide[WIDTH];
                flags_o.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow (a < b unsigned).
                wide          = {1'b0, a_i} - {1'b0, b_i};
                res_o         = wide[WIDTH-1:0];
                flags_o.carry = wide[WIDTH];
                flags_o.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SHL: begin
                res_o = a_i;
                if (shift_en_i) begin
                    res_o         = {a_i[WIDTH-2:0], 1'b0};
                    flags_o.carry = a_i[WIDTH-1];
                end
            end
            default: begin
                res_o = a_i;
                if (shift_en_i) begin
                    res_o         = {1'b0, a_i[WIDTH-1:1]};
                    flags_o.carry = a_i[0];
                end
            end
        endcase
        flags_o.zero = (res_o == '0);
        flags_o.neg  = res_o[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: accept in IDLE, compute in EXEC (shifts one bit per cycle),
// present registered result/flags in HOLD until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0] core_res;
    flags_t           core_flags;

    // a_q doubles as the shift accumulator; cnt_q counts remaining shift steps.
    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .shift_en_i (cnt_q != 2'd0),
        .res_o      (core_res),
        .flags_o    (core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = is_shift(op) ? b[1:0] : 2'd0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (is_shift(op_q) && cnt_q > 2'd1) begin
                    a_d   = core_res;
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    // Final step (or the only step): publish result and flags together.
                    result_d = core_res;
                    flags_d  = core_flags;
                    cnt_d    = 2'd0;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_HOLD);
    assign result    = result_q;
    assign carry     = flags_q.carry;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.neg;
    assign overflow  = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases pinned to hand-computed values, then
// randomized traffic compared every cycle against an arithmetic model.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, carry, zero, negative, overflow, busy;
    logic [W-1:0] result;

    int n_pass = 0;
    int n_total = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference: result, carry, overflow and latency straight from the op definitions.
    function automatic void calc(input int o, input int x, input int y,
                                 output int r, output int c, output int v, output int lat);
        int mask, s, n;
        mask = (1 << W) - 1;
        n = y % 4;
        c = 0; v = 0; lat = 1; r = 0;
        case (o)
            0: r = ~x & mask;
            1: r = x & y;
            2: r = x | y;
            3: r = x ^ y;
            4: begin
                s = x + y; r = s & mask; c = int'(s > mask);
                s = to_signed(x) + to_signed(y);
                v = int'(s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1)));
            end
            5: begin
                r = (x - y) & mask; c = int'(x < y);
                s = to_signed(x) - to_signed(y);
                v = int'(s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1)));
            end
            6: begin
                r = (x << n) & mask; c = (n != 0) ? (x >> (W - n)) & 1 : 0;
                lat = (n != 0) ? n : 1;
            end
            default: begin
                r = x >> n; c = (n != 0) ? (x >> (n - 1)) & 1 : 0;
                lat = (n != 0) ? n : 1;
            end
        endcase
    endfunction

    // Model: cycles until result, and whether a result is being offered.
    int m_cnt = 0;
    bit m_valid = 1'b0;
    int m_r = 0, m_c = 0, m_v = 0;
    int p_r = 0, p_c = 0, p_v = 0, p_lat = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_valid = 1'b0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1'b1;
                m_r = p_r; m_c = p_c; m_v = p_v;
            end
        end else if (in_valid) begin
            calc(int'(op), int'(a), int'(b), p_r, p_c, p_v, p_lat);
            m_cnt = p_lat;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("in_ready", int'(in_ready), int'(!m_valid && m_cnt == 0));
            chk("busy", int'(busy), int'(m_valid || m_cnt > 0));
            if (m_valid && out_valid) begin
                chk("result", int'(result), m_r);
                chk("carry", int'(carry), m_c);
                chk("overflow", int'(overflow), m_v);
                chk("zero", int'(zero), int'(m_r == 0));
                chk("negative", int'(negative), (m_r >> (W - 1)) & 1);
            end
        end
    end

    task automatic run_op(input int o, input int x, input int y, input int er, input int ec,
                          input int ez, input int en, input int ev, input int elat, input int hold);
        int r, c, v, l, k;
        calc(o, x, y, r, c, v, l);
        chk("model_result", r, er);
        chk("model_carry", c, ec);
        chk("model_ovf", v, ev);
        chk("model_lat", l, elat);
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        in_valid = 1'b1; op = 3'(o); a = W'(x); b = W'(y); out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!out_valid && k < 20);
        chk("latency", k, elat);
        chk("lit_result", int'(result), er);
        chk("lit_carry", int'(carry), ec);
        chk("lit_zero", int'(zero), ez);
        chk("lit_negative", int'(negative), en);
        chk("lit_overflow", int'(overflow), ev);
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        end
        if (hold > 0) chk("hold_result", int'(result), er);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("exit_out_valid", int'(out_valid), 0);
        chk("exit_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({carry, zero, negative, overflow}), 0);
        #11 rst_n = 1'b1;

        //      op  a        b        res      c z n v lat hold
        run_op(0, 'b1010, 'b0000, 'b0101, 0, 0, 0, 0, 1, 0);
        run_op(1, 'b1100, 'b1010, 'b1000, 0, 0, 1, 0, 1, 0);
        run_op(4, 'b0111, 'b0001, 'b1000, 0, 0, 1, 1, 1, 0);
        run_op(4, 'b1111, 'b0001, 'b0000, 1, 1, 0, 0, 1, 0);
        run_op(5, 'b0011, 'b0101, 'b1110, 1, 0, 1, 0, 1, 0);
        run_op(5, 'b1000, 'b0001, 'b0111, 0, 0, 0, 1, 1, 5);
        run_op(3, 'b0101, 'b0101, 'b0000, 0, 1, 0, 0, 1, 0);
        run_op(6, 'b1011, 'b0011, 'b1000, 1, 0, 1, 0, 3, 0);
        run_op(7, 'b1001, 'b0010, 'b0010, 0, 0, 0, 0, 2, 0);
        run_op(7, 'b0110, 'b0000, 'b0110, 0, 0, 0, 0, 1, 0);

        // Reset in the second EXEC cycle of SHL n=3, off any clock edge.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b110; a = 4'b1011; b = 4'b0011;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_result", int'(result), 0);
        chk("arst_flags", int'({carry, zero, negative, overflow}), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_busy", int'(busy), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst_no_valid", int'(out_valid), 0);
        end

        repeat (800) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            op        = 3'($urandom);
            a         = W'($urandom);
            b         = W'($urandom);
            out_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
